// File: rtl/result_streamer.sv
// result_streamer: reads `count` consecutive words from the result memory
// starting at `base` and presents them as a valid/ready stream with a
// final-word flag. A 2-entry skid FIFO absorbs read latency and backpressure.
// Optional build macro: RESULT_STREAM_RELU_EN (clamps negative words to 0 on output).
module result_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_adr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q, issued;
    logic              inflight, inflight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        occ;
    logic              done_q;

    logic              accept, zero_start, done_nxt;
    logic              issue, push, pop, fin;
    logic [2:0]        credit_used;
    logic [DATA_W-1:0] head;

    // FIFO head and handshake; a word popped with its last flag ends the transfer
    assign out_valid   = (occ != 2'd0);
    assign pop         = out_valid & out_ready;
    assign push        = inflight;
    assign head        = fifo_data[rd_ptr];
    assign out_last    = out_valid & fifo_last[rd_ptr];
    assign fin         = pop & fifo_last[rd_ptr];

    // Buffered plus in-flight words, less the one leaving this cycle, must stay below 2
    assign credit_used = {1'b0, occ} + {2'b0, inflight};
    assign issue       = (state == RUN) && (issued < count_q) &&
                         (credit_used < (3'd2 + {2'b0, pop}));

    assign mem_rd_en   = issue;
    assign mem_rd_adr  = base_q + ADDR_W'(issued);
    assign busy        = (state != IDLE);
    assign done        = done_q;

`ifdef RESULT_STREAM_RELU_EN
    assign out_data = head[DATA_W-1] ? '0 : head;
`else
    assign out_data = head;
`endif

    // Next-state logic: launch, issue phase, drain phase
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        zero_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            RUN: begin
                if (fin)                   state_nxt = IDLE;
                else if (issued == count_q) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (fin) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = zero_start | fin;
    end

    // Control state: FSM, captured transfer parameters, issue counter, read pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            base_q        <= '0;
            count_q       <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            done_q        <= done_nxt;
            inflight      <= issue;
            inflight_last <= issue && (issued == count_q - ONE);
            if (accept) begin
                base_q  <= base;
                count_q <= count;
                issued  <= '0;
            end else if (issue) begin
                issued <= issued + ONE;
            end
        end
    end

    // Skid FIFO: returning read word pushed one cycle after issue, popped on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            occ          <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
